// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide chunks in a WIDTH-bit operand.
  function automatic int unsigned digit_count(input int unsigned width,
                                              input int unsigned digit);
    return width / digit;
  endfunction

  // Counter width able to hold 0..digit_count inclusive.
  function automatic int unsigned cnt_width(input int unsigned width,
                                            input int unsigned digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Operand request / compare result channel of the serial magnitude comparator.
interface serial_magnitude_comparator_if
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 2
);

  localparam int unsigned CNT_W = cnt_width(WIDTH, DIGIT);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             eq;
  logic             gt;
  logic [CNT_W-1:0] cycles;

  modport master (
    output in_valid, a_in, b_in, signed_mode, out_ready,
    input  in_ready, out_valid, lt, eq, gt, cycles
  );

  modport slave (
    input  in_valid, a_in, b_in, signed_mode, out_ready,
    output in_ready, out_valid, lt, eq, gt, cycles
  );

endinterface

// File: rtl/serial_cmp_digit.sv
// Combinational unsigned compare of one DIGIT-wide chunk.
module serial_cmp_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  // Three-way relation of the two chunks.
  always_comb begin
    lt = (a < b);
    eq = (a == b);
    gt = (a > b);
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator, MSB chunk first, with early termination.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  serial_magnitude_comparator_if.slave bus
);

  localparam int unsigned N     = digit_count(WIDTH, DIGIT);
  localparam int unsigned CNT_W = cnt_width(WIDTH, DIGIT);

  // Reject illegal geometry at elaboration.
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_magnitude_comparator: WIDTH must be >= 2");
  end
  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_magnitude_comparator: DIGIT must divide WIDTH exactly");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             in_ready_q;
  logic             out_valid_q;

  logic dig_lt, dig_eq, dig_gt;

  serial_cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (a_q[WIDTH-1 -: DIGIT]),
    .b  (b_q[WIDTH-1 -: DIGIT]),
    .lt (dig_lt),
    .eq (dig_eq),
    .gt (dig_gt)
  );

  // Next-state and datapath update; operands are only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d   = bus.a_in;
          b_d   = bus.b_in;
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          if (bus.signed_mode) begin
            a_d[WIDTH-1] = ~bus.a_in[WIDTH-1];
            b_d[WIDTH-1] = ~bus.b_in[WIDTH-1];
          end
          cnt_d   = '0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + CNT_W'(1);
        if (!dig_eq) begin
          lt_d    = dig_lt;
          gt_d    = dig_gt;
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(N - 1)) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; handshake flags track the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.lt        = lt_q;
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.cycles    = cnt_q;

endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 2, bits compared per cycle; SHALL divide WIDTH exactly, else elaboration error.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands and mode are presented.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 a_in  input  WIDTH  operand A.
REQ-008 b_in  input  WIDTH  operand B.
REQ-009 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
REQ-010 out_valid  output  1  result fields are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 lt / eq / gt  output  1 each  A<B / A==B / A>B; exactly one high while out_valid.
REQ-013 cycles  output  clog2(WIDTH/DIGIT+1)  number of SCAN cycles used by this result.

Function
REQ-014 FSM SHALL have states IDLE, SCAN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on in_valid, capture a_in, b_in and signed_mode into shift registers, clear cycle counter, go to SCAN.
REQ-016 Signed mode: at capture, invert bit WIDTH-1 of both captured operands; the unsigned compare then yields the signed result.
REQ-017 SCAN: each cycle compare top DIGIT bits of A and B; increment cycle counter; shift both registers left by DIGIT.
REQ-018 First unequal digit: register lt/gt from that digit, eq=0, go to DONE (early termination).
REQ-019 Last digit (chunk N = WIDTH/DIGIT) equal: register eq=1, go to DONE.
REQ-020 Latency from accept to out_valid SHALL be k cycles, k = 1-based index (MSB first) of first differing digit, or N if equal.
REQ-021 DONE: lt/eq/gt/cycles SHALL remain stable until out_ready; on out_ready go to IDLE.
REQ-022 No bypass: a new operation is accepted earliest the cycle after the result handshake.
REQ-023 in_valid asserted outside IDLE SHALL be ignored; operands changing during SCAN SHALL not affect the result.

Reset
REQ-024 reset SHALL force state IDLE, lt=eq=gt=0, cycles=0, out_valid=0, in_ready=1 the following cycle.
REQ-025 reset in SCAN or DONE SHALL abort the operation; the aborted result SHALL never appear on out_valid.
REQ-026 reset SHALL dominate in_valid and out_ready in the same cycle.

Structure
REQ-027 Shared package serial_cmp_pkg SHALL hold the state enum (IDLE, SCAN, DONE) and a constant function for digit count and counter width.
REQ-028 Digit compare SHALL be a combinational sub-module serial_cmp_digit (DIGIT-bit inputs, lt/eq/gt outputs), instantiated once.
REQ-029 Block SHALL contain no delays and no multiple drivers; each register written in one clocked process.

Verification (WIDTH=8, DIGIT=2, N=4)
REQ-030 Unsigned a=0x80 b=0x7F -> gt=1, eq=0, out_valid 1 cycle after accept, cycles=1.
REQ-031 Unsigned a=b=0x5A -> eq=1, out_valid 4 cycles after accept, cycles=4.
REQ-032 a=0x80 b=0x01: signed_mode=1 -> lt=1, cycles=1; signed_mode=0 -> gt=1, cycles=1.
REQ-033 a=0x13 b=0x12 with out_ready low 3 cycles after out_valid -> gt=1, cycles=4, outputs stable, in_ready=0 until handshake, next op accepted cycle after.
REQ-034 reset asserted 2 cycles into SCAN of a=b=0xFF -> out_valid never asserts, in_ready=1 next cycle, next op a=0x01 b=0x02 -> lt=1, cycles=4.
